// File: rtl/wb_reg_bridge_if.sv
// Wishbone classic slave bus bundle used between the master and wb_reg_bridge.
// Signal names keep the slave-side _i/_o orientation in both modports.
interface wb_reg_bridge_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic            wbs_cyc_i;
  logic            wbs_stb_i;
  logic            wbs_we_i;
  logic [AW-1:0]   wbs_adr_i;
  logic [DW-1:0]   wbs_dat_i;
  logic [DW/8-1:0] wbs_sel_i;
  logic [DW-1:0]   wbs_dat_o;
  logic            wbs_ack_o;
  logic            wbs_err_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );
endinterface

// File: rtl/wb_reg_bridge.sv
// Wishbone classic slave to held-strobe register bus bridge with a watchdog
// that turns a missing reg_ack into a one-cycle Wishbone error.
module wb_reg_bridge #(
  parameter int AW      = 9,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            app_clk,
  input  logic            app_rst,
  wb_reg_bridge_if.slave  wb,
  output logic            reg_cs,
  output logic            reg_wr,
  output logic [AW-1:0]   reg_addr,
  output logic [DW-1:0]   reg_wdata,
  output logic [DW/8-1:0] reg_be,
  input  logic [DW-1:0]   reg_rdata,
  input  logic            reg_ack,
  output logic            err_flag_o,
  input  logic            err_clr_i
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state_q;
  logic [TW-1:0]     timer_q;
  logic              cs_q, wr_q, ack_q, err_q, err_flag_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q, dat_q;
  logic [DW/8-1:0]   be_q;
  logic              timeout_hit;
  logic              err_set_d;
  logic              err_flag_d;

  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TLIM);
  // A master abort outranks everything; an ack on the expiry edge outranks the timeout.
  assign err_set_d   = (state_q == REQ) && wb.wbs_cyc_i && !reg_ack && timeout_hit;
  assign err_flag_d  = err_set_d | (err_flag_q & ~err_clr_i);

  always_ff @(posedge app_clk or posedge app_rst) begin
    if (app_rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      dat_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      err_flag_q <= err_flag_d;
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          dat_q <= '0;
          if (wb.wbs_cyc_i && wb.wbs_stb_i) begin
            wr_q    <= wb.wbs_we_i;
            addr_q  <= wb.wbs_adr_i;
            wdata_q <= wb.wbs_dat_i;
            be_q    <= wb.wbs_sel_i;
            cs_q    <= 1'b1;
            timer_q <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (timer_q != '1) timer_q <= timer_q + TW'(1);
          if (!wb.wbs_cyc_i) begin
            cs_q    <= 1'b0;
            state_q <= IDLE;
          end else if (reg_ack) begin
            cs_q    <= 1'b0;
            dat_q   <= wr_q ? '0 : reg_rdata;
            ack_q   <= 1'b1;
            state_q <= RESP;
          end else if (timeout_hit) begin
            cs_q    <= 1'b0;
            dat_q   <= '1;
            err_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          dat_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb.wbs_dat_o = dat_q;
  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_err_o = err_q;
  assign reg_cs       = cs_q;
  assign reg_wr       = wr_q;
  assign reg_addr     = addr_q;
  assign reg_wdata    = wdata_q;
  assign reg_be       = be_q;
  assign err_flag_o   = err_flag_q;

endmodule

// File: tb/tb_wb_reg_bridge.sv
// Randomized bench for wb_reg_bridge: a transaction-level model predicts
// outcome, cs duration, response data and the sticky error flag.
module tb_wb_reg_bridge;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int T  = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reg_cs, reg_wr;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata, reg_rdata;
  logic [3:0]    reg_be;
  logic          reg_ack = 1'b0;
  logic          err_flag_o;
  logic          err_clr_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic mflag = 1'b0;

  wb_reg_bridge_if #(.AW(AW), .DW(DW)) wb ();

  wb_reg_bridge #(.AW(AW), .DW(DW), .TIMEOUT(T)) dut (
    .app_clk   (clk),
    .app_rst   (rst),
    .wb        (wb),
    .reg_cs    (reg_cs),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_be    (reg_be),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .err_flag_o(err_flag_o),
    .err_clr_i (err_clr_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic cyc, input logic we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [3:0] sel);
    wb.wbs_cyc_i = cyc;
    wb.wbs_stb_i = cyc;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = dat;
    wb.wbs_sel_i = sel;
  endtask

  // lat = cycles after reg_cs first seen high before the target asserts reg_ack; -1 = never.
  task automatic run_txn(input string tag, input logic we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [3:0] sel,
                         input int lat, input logic [DW-1:0] rd, input logic clr_during);
    bit        exp_ack;
    int        exp_cs, k, cs_hi;
    bit        done;
    logic [DW-1:0] exp_dat;
    exp_ack = (lat >= 0) && (lat + 1 <= T);
    exp_cs  = exp_ack ? lat + 1 : T;
    exp_dat = exp_ack ? (we ? '0 : rd) : '1;
    set_bus(1'b1, we, adr, dat, sel);
    tick();
    chk({tag, "_cs_rise"}, reg_cs, 1'b1);
    chk({tag, "_fields"}, {reg_wr, reg_addr, reg_wdata, reg_be}, {we, adr, dat, sel});
    err_clr_i = clr_during;
    k = 0; cs_hi = 1; done = 0;
    while (!done && k < 400) begin
      reg_ack   = (k == lat);
      reg_rdata = (k == lat) ? rd : $urandom;
      tick();
      k++;
      reg_ack = 1'b0;
      if (wb.wbs_ack_o || wb.wbs_err_o) done = 1;
      else if (reg_cs) begin
        cs_hi++;
        if ({reg_wr, reg_addr, reg_wdata, reg_be} !== {we, adr, dat, sel})
          chk({tag, "_stable"}, {reg_wr, reg_addr, reg_wdata, reg_be}, {we, adr, dat, sel});
      end
    end
    if (clr_during) mflag = 1'b0;
    if (!exp_ack) mflag = 1'b1;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_ack"}, wb.wbs_ack_o, exp_ack);
    chk({tag, "_err"}, wb.wbs_err_o, !exp_ack);
    chk({tag, "_dat"}, wb.wbs_dat_o, exp_dat);
    chk({tag, "_cs_len"}, cs_hi, exp_cs);
    chk({tag, "_cs_low"}, reg_cs, 1'b0);
    chk({tag, "_flag"}, err_flag_o, mflag);
    err_clr_i = 1'b0;
    set_bus(1'b0, 1'b0, '0, '0, '0);
    tick();
    chk({tag, "_pulse"}, {wb.wbs_ack_o, wb.wbs_err_o, wb.wbs_dat_o}, '0);
    chk({tag, "_no_dup"}, reg_cs, 1'b0);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      reg_ack = $urandom_range(0, 1) == 1;
      tick();
      chk("idle_quiet", {reg_cs, wb.wbs_ack_o, wb.wbs_err_o}, 3'b000);
    end
    reg_ack = 1'b0;
  endtask

  initial begin
    set_bus(1'b0, 1'b0, '0, '0, '0);
    reg_rdata = '0;
    #1;
    chk("rst_outs", {reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, wb.wbs_ack_o, wb.wbs_err_o,
                     err_flag_o}, '0);
    chk("rst_dat", wb.wbs_dat_o, '0);
    tick();
    rst = 1'b0;
    tick();

    run_txn("t1_wr", 1'b1, 9'h008, 32'h0000_00A5, 4'h1, 1, 32'hDEAD_BEEF, 1'b0);
    run_txn("t2_rd", 1'b0, 9'h100, 32'h0, 4'hF, 5, 32'h1234_5678, 1'b0);
    run_txn("t3_to", 1'b0, 9'h0F0, 32'h0, 4'hF, -1, 32'h0, 1'b0);
    idle_gap(2);
    chk("t3_flag_hold", err_flag_o, 1'b1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    mflag = 1'b0;
    chk("t3_flag_clr", err_flag_o, 1'b0);
    run_txn("t6_race", 1'b0, 9'h044, 32'h0, 4'hF, T - 1, 32'hCAFE_F00D, 1'b0);
    run_txn("t3b_setdom", 1'b1, 9'h010, 32'h5555_AAAA, 4'h3, -1, 32'h0, 1'b1);

    // master abort three cycles into REQ, then a stray ack while idle
    set_bus(1'b1, 1'b0, 9'h1FC, 32'h0, 4'hF);
    tick();
    chk("t4_cs", reg_cs, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    set_bus(1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("t4_abort", {reg_cs, wb.wbs_ack_o, wb.wbs_err_o}, 3'b000);
    reg_ack = 1'b1;
    reg_rdata = 32'h0BAD_0BAD;
    tick();
    reg_ack = 1'b0;
    chk("t4_late_ack", {reg_cs, wb.wbs_ack_o, wb.wbs_err_o}, 3'b000);
    tick();
    chk("t4_late_ack2", {reg_cs, wb.wbs_ack_o, wb.wbs_err_o, wb.wbs_dat_o}, '0);
    run_txn("t4_next", 1'b0, 9'h020, 32'h0, 4'hF, 2, 32'h7777_1111, 1'b0);

    // reset in the middle of a request, with a sticky error pending
    run_txn("t5_pre", 1'b0, 9'h030, 32'h0, 4'hF, -1, 32'h0, 1'b0);
    set_bus(1'b1, 1'b1, 9'h0AA, 32'h1357_9BDF, 4'hC);
    tick();
    chk("t5_cs", reg_cs, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    mflag = 1'b0;
    chk("t5_async", {reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, wb.wbs_ack_o, wb.wbs_err_o,
                     err_flag_o}, '0);
    set_bus(1'b0, 1'b0, '0, '0, '0);
    tick();
    rst = 1'b0;
    tick();
    run_txn("t5_after", 1'b0, 9'h0AC, 32'h0, 4'hF, 3, 32'h2468_ACE0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      logic          we;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat, rd;
      logic [3:0]    sel;
      int            lat;
      we  = $urandom_range(0, 1) == 1;
      adr = AW'($urandom);
      dat = $urandom;
      rd  = $urandom;
      sel = 4'($urandom);
      lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 10));
      run_txn("rand", we, adr, dat, sel, lat, rd, $urandom_range(0, 3) == 0);
      idle_gap(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
